// File: rtl/cas_player_if.sv
// Byte stream from the tape-image buffer into the cassette player.
// A byte moves on any cycle where din_valid and din_ready are both high.
interface cas_player_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/cas_player.sv
// CoCo/Dragon cassette playback: bytes become FSK cycles on casdout, LSB first.
// A 0 bit is one 1200 Hz cycle and a 1 bit is one 2400 Hz cycle. The motor relay freezes playback.
module cas_player #(
  parameter int HALF_0 = 17898,
  parameter int HALF_1 = 8949,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               motor,
  cas_player_if.slave        tape,
  output logic               casdout,
  output logic               active,
  output logic [15:0]        byte_count,
  output logic [11:0]        snd
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] H0_M1 = CNT_W'(HALF_0 - 1);
  localparam logic [CNT_W-1:0] H1_M1 = CNT_W'(HALF_1 - 1);

  state_t           state, state_n;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       bitcnt, bitcnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last, xfer;

  // The byte boundary is the final LOW cycle of bit 7; a new byte may load there with no gap.
  assign last           = (state == LOW) && (cnt == '0) && (bitcnt == 3'd7);
  assign tape.din_ready = reset_n & motor & ((state == IDLE) | last);
  assign xfer           = tape.din_ready & tape.din_valid;

  assign casdout = (state == HIGH);
  assign active  = (state != IDLE);
  assign snd     = casdout ? 12'h200 : 12'h000;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      cnt        <= '0;
      byte_count <= '0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      cnt        <= cnt_n;
      byte_count <= byte_count + {15'd0, xfer};
    end
  end

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    cnt_n    = cnt;
    if (motor) begin
      case (state)
        HIGH: begin
          if (cnt == '0) begin
            state_n = LOW;
            cnt_n   = shreg[0] ? H1_M1 : H0_M1;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (bitcnt != 3'd7) begin
            shreg_n  = {1'b0, shreg[7:1]};
            bitcnt_n = bitcnt + 3'd1;
            cnt_n    = shreg[1] ? H1_M1 : H0_M1;
            state_n  = HIGH;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // A transfer can only happen in IDLE or on the last LOW cycle, and it overrides both.
    if (xfer) begin
      shreg_n  = tape.din;
      bitcnt_n = 3'd0;
      cnt_n    = tape.din[0] ? H1_M1 : H0_M1;
      state_n  = HIGH;
    end
  end

endmodule

// File: tb/tb_cas_player.sv
// Directed bench for cas_player with short half-cycles (HALF_0=6, HALF_1=3).
module tb_cas_player;
  localparam int HALF_0 = 6;
  localparam int HALF_1 = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        motor;
  logic        casdout;
  logic        active;
  logic [15:0] byte_count;
  logic [11:0] snd;

  int n_checks = 0;
  int n_fails  = 0;

  cas_player_if tape_if ();

  cas_player #(.HALF_0(HALF_0), .HALF_1(HALF_1), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .motor      (motor),
    .tape       (tape_if),
    .casdout    (casdout),
    .active     (active),
    .byte_count (byte_count),
    .snd        (snd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rn, input logic m, input logic v, input logic [7:0] d);
    reset_n           = rn;
    motor             = m;
    tape_if.din_valid = v;
    tape_if.din       = d;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walks one byte from its first HIGH cycle up to the edge after its final LOW cycle.
  task automatic checkByteWave(input string tag, input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      int h;
      h = b[i] ? HALF_1 : HALF_0;
      for (int j = 0; j < h; j++) begin
        checkOutput($sformatf("%s bit%0d high", tag, i), casdout, 1);
        checkOutput($sformatf("%s bit%0d ready_h", tag, i), tape_if.din_ready, 0);
        tick();
      end
      for (int j = 0; j < h; j++) begin
        checkOutput($sformatf("%s bit%0d low", tag, i), casdout, 0);
        checkOutput($sformatf("%s bit%0d active", tag, i), active, 1);
        checkOutput($sformatf("%s bit%0d ready_l", tag, i), tape_if.din_ready,
                    {31'd0, (i == 7) && (j == h - 1)});
        tick();
      end
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  initial begin
    // Motor off with data offered from reset: nothing may move.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF);
    tick();
    tick();
    checkOutput("rst casdout", casdout, 0);
    checkOutput("rst active", active, 0);
    checkOutput("rst byte_count", byte_count, 0);
    checkOutput("rst snd", snd, 0);
    checkOutput("rst ready", tape_if.din_ready, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      checkOutput("motoroff ready", tape_if.din_ready, 0);
      checkOutput("motoroff casdout", casdout, 0);
      tick();
    end
    checkOutput("motoroff byte_count", byte_count, 0);

    // Single byte 0xA5, then underrun to IDLE.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA5);
    checkOutput("a5 ready idle", tape_if.din_ready, 1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h3C);
    checkOutput("a5 snd high", snd, 12'h200);
    checkOutput("a5 byte_count", byte_count, 1);
    checkByteWave("a5", 8'hA5);
    checkOutput("a5 end active", active, 0);
    checkOutput("a5 end casdout", casdout, 0);
    checkOutput("a5 end snd", snd, 0);
    checkOutput("a5 end ready", tape_if.din_ready, 1);
    checkOutput("a5 end byte_count", byte_count, 1);

    // 0x00 then 0xFF back-to-back with valid held high.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF);
    checkByteWave("b00", 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("bff byte_count", byte_count, 2);
    checkByteWave("bff", 8'hFF);
    checkOutput("bff end active", active, 0);
    checkOutput("bff end byte_count", byte_count, 2);

    // 0x01 with the motor dropped for 10 cycles after two HIGH cycles.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h01);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("m01 high c1", casdout, 1);
    tick();
    checkOutput("m01 high c2", casdout, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 10; i++) begin
      checkOutput("m01 frozen casdout", casdout, 1);
      checkOutput("m01 frozen ready", tape_if.din_ready, 0);
      checkOutput("m01 frozen active", active, 1);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("m01 resume high", casdout, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput("m01 resume low", casdout, 0);
      tick();
    end
    checkOutput("m01 bit1 high", casdout, 1);
    checkOutput("m01 byte_count", byte_count, 1);

    // Underrun after 0x55, then a later byte 0x80 starts cleanly.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkByteWave("b55", 8'h55);
    for (int i = 0; i < 5; i++) begin
      checkOutput("under idle casdout", casdout, 0);
      checkOutput("under idle active", active, 0);
      if (i < 4) tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h80);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("b80 byte_count", byte_count, 2);
    checkByteWave("b80", 8'h80);
    checkOutput("b80 end active", active, 0);

    // Reset in the middle of bit 3 of 0xC3.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC3);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 27; i++) tick();
    checkOutput("c3 mid casdout", casdout, 1);
    checkOutput("c3 mid active", active, 1);
    checkOutput("c3 mid byte_count", byte_count, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
    checkOutput("c3 rst ready comb", tape_if.din_ready, 0);
    tick();
    checkOutput("c3 rst casdout", casdout, 0);
    checkOutput("c3 rst active", active, 0);
    checkOutput("c3 rst byte_count", byte_count, 0);
    checkOutput("c3 rst ready", tape_if.din_ready, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    tick();
    checkOutput("c3 post active", active, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
